lb_slot_pool: RTL and testbench

Per-core free-slot descriptor pool feeding the hash load balancer's descriptor allocation path. It holds one circular tag FIFO per core. On `desc_pop` it hands out `{core, tag}` for the balancer's `selected_core`, and it takes tags back when cores release slots. It also serves one-at-a-time intercore descriptor requests and publishes per-core `slot_counts/valids/busys/ins_errs` status to the balancer.

---
 rtl/lb_slot_pool.sv | 214 +++++++++++++++++++++
 tb/tb_lb_slot_pool.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_slot_pool.sv
// lb_slot_pool: per-core circular pools of free slot tags. The balancer
// pops {core, tag} descriptors, cores release tags back, and a
// one-at-a-time intercore port borrows descriptors. A small IDLE/FILL FSM
// loads a core's pool with tags 1..N, one tag per cycle.
//
// Handshake: an intercore request is taken on a cycle where
// ic_req_valid && ic_req_ready. The registered request pops the head on
// the following cycle, and ic_resp_valid pulses for one cycle after that.
// ic_req_ready stays low while a request is pending.
module lb_slot_pool #(
    parameter int CORE_COUNT    = 8,
    parameter int SLOT_COUNT    = 32,
    parameter int SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
    parameter int TAG_WIDTH     = (SLOT_WIDTH > 5) ? SLOT_WIDTH : 5,
    parameter int ID_TAG_WIDTH  = CORE_ID_WIDTH + TAG_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    input  logic [CORE_ID_WIDTH-1:0]         cfg_core,
    input  logic [SLOT_WIDTH-1:0]            cfg_count,
    input  logic [CORE_COUNT-1:0]            slots_flush,
    input  logic [CORE_ID_WIDTH-1:0]         selected_core,
    input  logic                             desc_pop,
    output logic [ID_TAG_WIDTH-1:0]          desc_data,
    input  logic                             free_valid,
    input  logic [ID_TAG_WIDTH-1:0]          free_desc,
    input  logic                             ic_req_valid,
    input  logic [CORE_ID_WIDTH-1:0]         ic_req_core,
    output logic                             ic_req_ready,
    output logic                             ic_resp_valid,
    output logic [ID_TAG_WIDTH-1:0]          ic_resp_desc,
    output logic                             ic_resp_ok,
    output logic [CORE_COUNT*SLOT_WIDTH-1:0] slot_counts,
    output logic [CORE_COUNT-1:0]            slot_valids,
    output logic [CORE_COUNT-1:0]            slot_busys,
    output logic [CORE_COUNT-1:0]            slot_ins_errs
);

    localparam int PTR_WIDTH = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state_q, state_d;

    logic [TAG_WIDTH-1:0]     mem    [CORE_COUNT][SLOT_COUNT];
    logic [PTR_WIDTH-1:0]     rd_ptr [CORE_COUNT];
    logic [PTR_WIDTH-1:0]     wr_ptr [CORE_COUNT];
    logic [SLOT_WIDTH-1:0]    cnt    [CORE_COUNT];
    logic [SLOT_WIDTH-1:0]    max_r  [CORE_COUNT];
    logic [TAG_WIDTH-1:0]     head   [CORE_COUNT];
    logic [TAG_WIDTH-1:0]     wr_tag [CORE_COUNT];
    logic [CORE_COUNT-1:0]    err_r, valid_r;

    logic [CORE_ID_WIDTH-1:0] fill_core;
    logic [SLOT_WIDTH-1:0]    fill_k, fill_max, cfg_max;
    logic                     cfg_go;

    logic                     ic_pend, resp_valid_r, resp_ok_r;
    logic [CORE_ID_WIDTH-1:0] ic_core;
    logic [ID_TAG_WIDTH-1:0]  resp_desc_r;

    logic [CORE_COUNT-1:0]    fill_busy, ic_busy, pop_do, ic_pop, wr_do, free_err;
    logic [CORE_ID_WIDTH-1:0] free_core;
    logic [TAG_WIDTH-1:0]     free_tag;
    logic                     ic_pop_any;

    function automatic logic [PTR_WIDTH-1:0] inc_ptr(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_WIDTH'(SLOT_COUNT - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign free_core = free_desc[ID_TAG_WIDTH-1:TAG_WIDTH];
    assign free_tag  = free_desc[TAG_WIDTH-1:0];
    assign cfg_max   = (cfg_count > SLOT_WIDTH'(SLOT_COUNT)) ? SLOT_WIDTH'(SLOT_COUNT) : cfg_count;

    // Fill sequencer: accept a config in IDLE, then write one tag per cycle.
    always_comb begin
        state_d = state_q;
        cfg_go  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && !slots_flush[cfg_core]) begin
                    cfg_go  = 1'b1;
                    state_d = (cfg_max != '0) ? FILL : IDLE;
                end
            end
            FILL: begin
                if (slots_flush[fill_core] || fill_k >= fill_max) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-core pop/free/fill decisions; flush on a core suppresses all of them.
    always_comb begin
        for (int c = 0; c < CORE_COUNT; c++) begin
            head[c]      = mem[c][rd_ptr[c]];
            fill_busy[c] = (state_q == FILL) && (fill_core == CORE_ID_WIDTH'(c));
            ic_busy[c]   = ic_pend && (ic_core == CORE_ID_WIDTH'(c));
            ic_pop[c]    = ic_busy[c] && (cnt[c] != '0) && !fill_busy[c] && !slots_flush[c];
            pop_do[c]    = ic_pop[c] ||
                           (desc_pop && (selected_core == CORE_ID_WIDTH'(c)) && (cnt[c] != '0) &&
                            !fill_busy[c] && !ic_busy[c] && !slots_flush[c]);
            free_err[c]  = 1'b0;
            wr_do[c]     = 1'b0;
            wr_tag[c]    = free_tag;
            if (fill_busy[c] && !slots_flush[c]) begin
                wr_do[c]  = 1'b1;
                wr_tag[c] = TAG_WIDTH'(fill_k);
            end else if (free_valid && (free_core == CORE_ID_WIDTH'(c)) &&
                         !fill_busy[c] && !slots_flush[c]) begin
                if ((free_tag == '0) || (free_tag > TAG_WIDTH'(max_r[c])) || (cnt[c] == max_r[c]))
                    free_err[c] = 1'b1;
                else
                    wr_do[c] = 1'b1;
            end
        end
        ic_pop_any = |ic_pop;
    end

    // FSM state and fill progress registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            fill_core <= '0;
            fill_k    <= '0;
            fill_max  <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_go) begin
                fill_core <= cfg_core;
                fill_k    <= SLOT_WIDTH'(1);
                fill_max  <= cfg_max;
            end else if (state_q == FILL) begin
                fill_k <= fill_k + 1'b1;
            end
        end
    end

    // Per-core pointers, counts, sizes, sticky errors and valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CORE_COUNT; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                cnt[c]    <= '0;
                max_r[c]  <= '0;
            end
            err_r   <= '0;
            valid_r <= '0;
        end else begin
            for (int c = 0; c < CORE_COUNT; c++) begin
                if (slots_flush[c] || (cfg_go && cfg_core == CORE_ID_WIDTH'(c))) begin
                    rd_ptr[c] <= '0;
                    wr_ptr[c] <= '0;
                    cnt[c]    <= '0;
                    max_r[c]  <= slots_flush[c] ? '0 : cfg_max;
                    err_r[c]  <= 1'b0;
                end else begin
                    if (pop_do[c]) rd_ptr[c] <= inc_ptr(rd_ptr[c]);
                    if (wr_do[c])  wr_ptr[c] <= inc_ptr(wr_ptr[c]);
                    cnt[c] <= cnt[c] - SLOT_WIDTH'(pop_do[c]) + SLOT_WIDTH'(wr_do[c]);
                    if (free_err[c]) err_r[c] <= 1'b1;
                end
                valid_r[c] <= (cnt[c] != '0) && !fill_busy[c] && !slots_flush[c] &&
                              !(cfg_go && cfg_core == CORE_ID_WIDTH'(c));
            end
        end
    end

    // Tag storage writes (fill or accepted release); contents need no reset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CORE_COUNT; c++) begin
            if (wr_do[c]) mem[c][wr_ptr[c]] <= wr_tag[c];
        end
    end

    // Intercore request register and one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_pend      <= 1'b0;
            ic_core      <= '0;
            resp_valid_r <= 1'b0;
            resp_ok_r    <= 1'b0;
            resp_desc_r  <= '0;
        end else begin
            ic_pend      <= ic_req_valid && !ic_pend;
            if (ic_req_valid && !ic_pend) ic_core <= ic_req_core;
            resp_valid_r <= ic_pend;
            if (ic_pend) begin
                resp_ok_r <= ic_pop_any;
                if (ic_pop_any) resp_desc_r <= {ic_core, head[ic_core]};
            end
        end
    end

    // Output packing.
    always_comb begin
        slot_counts = '0;
        for (int c = 0; c < CORE_COUNT; c++) slot_counts[c*SLOT_WIDTH +: SLOT_WIDTH] = cnt[c];
    end

    assign desc_data     = {selected_core, head[selected_core]};
    assign slot_valids   = valid_r;
    assign slot_busys    = fill_busy | ic_busy;
    assign slot_ins_errs = err_r;
    assign ic_req_ready  = !ic_pend;
    assign ic_resp_valid = resp_valid_r;
    assign ic_resp_ok    = resp_ok_r;
    assign ic_resp_desc  = resp_desc_r;

endmodule

// File: tb/tb_lb_slot_pool.sv
// Directed bench for lb_slot_pool: fills, pops, releases, release errors,
// intercore requests, flush during fill and asynchronous reset.
module tb_lb_slot_pool;

    localparam int CC = 8;
    localparam int SC = 32;
    localparam int SW = 6;
    localparam int CW = 3;
    localparam int TW = 6;
    localparam int IW = CW + TW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic [CW-1:0]  cfg_core = '0;
    logic [SW-1:0]  cfg_count = '0;
    logic [CC-1:0]  slots_flush = '0;
    logic [CW-1:0]  selected_core = '0;
    logic           desc_pop = 1'b0;
    logic [IW-1:0]  desc_data;
    logic           free_valid = 1'b0;
    logic [IW-1:0]  free_desc = '0;
    logic           ic_req_valid = 1'b0;
    logic [CW-1:0]  ic_req_core = '0;
    logic           ic_req_ready;
    logic           ic_resp_valid;
    logic [IW-1:0]  ic_resp_desc;
    logic           ic_resp_ok;
    logic [CC*SW-1:0] slot_counts;
    logic [CC-1:0]  slot_valids;
    logic [CC-1:0]  slot_busys;
    logic [CC-1:0]  slot_ins_errs;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [IW-1:0] exp_q[$];      // expected desc_data per pop
    logic [IW:0]   ic_exp_q[$];   // expected {ok, desc} per intercore request

    lb_slot_pool dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_core(cfg_core), .cfg_count(cfg_count),
        .slots_flush(slots_flush),
        .selected_core(selected_core), .desc_pop(desc_pop), .desc_data(desc_data),
        .free_valid(free_valid), .free_desc(free_desc),
        .ic_req_valid(ic_req_valid), .ic_req_core(ic_req_core), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_desc(ic_resp_desc), .ic_resp_ok(ic_resp_ok),
        .slot_counts(slot_counts), .slot_valids(slot_valids),
        .slot_busys(slot_busys), .slot_ins_errs(slot_ins_errs)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] cnt_of(input int c);
        return slot_counts[c*SW +: SW];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_cfg(input int c, input int n);
        cfg_valid = 1'b1;
        cfg_core  = CW'(c);
        cfg_count = SW'(n);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_pop(input int c, input int tag);
        logic [IW-1:0] e;
        selected_core = CW'(c);
        desc_pop = 1'b1;
        exp_q.push_back({CW'(c), TW'(tag)});
        #1;
        e = exp_q.pop_front();
        check("desc_data", desc_data, e);
        tick();
        desc_pop = 1'b0;
    endtask

    task automatic do_free(input int c, input int tag);
        free_valid = 1'b1;
        free_desc  = {CW'(c), TW'(tag)};
        tick();
        free_valid = 1'b0;
    endtask

    task automatic do_flush(input int c);
        slots_flush = '0;
        slots_flush[c] = 1'b1;
        tick();
        slots_flush = '0;
    endtask

    task automatic ic_request(input int c, input logic ok, input int tag);
        logic [IW:0] e;
        int waited;
        check("ic_ready_before", ic_req_ready, 1'b1);
        ic_exp_q.push_back({ok, CW'(c), TW'(tag)});
        ic_req_valid = 1'b1;
        ic_req_core  = CW'(c);
        tick();
        ic_req_valid = 1'b0;
        check("ic_busy_pending", slot_busys[c], 1'b1);
        check("ic_ready_pending", ic_req_ready, 1'b0);
        waited = 0;
        while (!ic_resp_valid && waited < 8) begin
            tick();
            waited++;
        end
        check("ic_resp_seen", ic_resp_valid, 1'b1);
        check("ic_latency", waited, 1);
        e = ic_exp_q.pop_front();
        check("ic_resp", {ic_resp_ok, ic_resp_desc}, e);
        check("ic_busy_after", slot_busys[c], 1'b0);
        tick();
        check("ic_resp_pulse", ic_resp_valid, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_counts", slot_counts, 0);
        check("rst_valids", slot_valids, 0);
        check("rst_busys", slot_busys, 0);
        check("rst_errs", slot_ins_errs, 0);
        check("rst_ready", ic_req_ready, 1'b1);
        check("rst_resp", {ic_resp_valid, ic_resp_ok, ic_resp_desc}, 0);

        // Config core 2 with 4 slots; valid rises N+1 cycles after cfg
        do_cfg(2, 4);
        check("fill_busy", slot_busys[2], 1'b1);
        check("fill_valid_low", slot_valids[2], 1'b0);
        repeat (4) tick();
        check("fill_count", cnt_of(2), 4);
        check("fill_valid_not_yet", slot_valids[2], 1'b0);
        tick();
        check("fill_valid", slot_valids[2], 1'b1);
        check("fill_busy_done", slot_busys[2], 1'b0);
        for (int k = 1; k <= 4; k++) do_pop(2, k);
        check("drain_count", cnt_of(2), 0);
        tick();
        check("drain_valid", slot_valids[2], 1'b0);
        desc_pop = 1'b1;
        selected_core = 3'd2;
        tick();
        desc_pop = 1'b0;
        check("pop_empty_count", cnt_of(2), 0);

        // Same-cycle pop and free on core 2 with count 3
        do_cfg(2, 4);
        repeat (5) tick();
        do_pop(2, 1);
        check("pf_count_before", cnt_of(2), 3);
        free_valid = 1'b1;
        free_desc  = {3'd2, 6'd1};
        do_pop(2, 2);
        free_valid = 1'b0;
        check("pf_count_same", cnt_of(2), 3);
        do_pop(2, 3);
        do_pop(2, 4);
        do_pop(2, 1);
        check("pf_count_end", cnt_of(2), 0);

        // Release errors on core 2 (max 4)
        for (int k = 1; k <= 4; k++) do_free(2, k);
        check("free_refill", cnt_of(2), 4);
        check("free_no_err", slot_ins_errs[2], 1'b0);
        do_free(2, 1);
        check("err_full", slot_ins_errs[2], 1'b1);
        check("err_full_count", cnt_of(2), 4);
        do_flush(2);
        check("flush_err", slot_ins_errs[2], 1'b0);
        check("flush_count", cnt_of(2), 0);
        do_cfg(2, 4);
        repeat (5) tick();
        do_pop(2, 1);
        do_free(2, 5);
        check("err_tag5", slot_ins_errs[2], 1'b1);
        check("err_tag5_count", cnt_of(2), 3);
        do_cfg(2, 4);
        check("cfg_clears_err", slot_ins_errs[2], 1'b0);
        repeat (4) tick();
        do_pop(2, 1);
        do_free(2, 0);
        check("err_tag0", slot_ins_errs[2], 1'b1);
        check("err_tag0_count", cnt_of(2), 3);
        do_flush(2);

        // Intercore on core 5 with one slot, then on the empty core
        do_cfg(5, 1);
        repeat (2) tick();
        check("ic_core_valid", slot_valids[5], 1'b1);
        ic_request(5, 1'b1, 1);
        check("ic_count_after", cnt_of(5), 0);
        ic_request(5, 1'b0, 1);
        check("ic_count_empty", cnt_of(5), 0);

        // Flush core 3 during its fill, then refill
        do_cfg(3, 8);
        tick();
        tick();
        do_flush(3);
        check("abort_count", cnt_of(3), 0);
        check("abort_busy", slot_busys[3], 1'b0);
        check("abort_valid", slot_valids[3], 1'b0);
        do_cfg(3, 8);
        repeat (9) tick();
        check("refill_count", cnt_of(3), 8);
        check("refill_valid", slot_valids[3], 1'b1);
        for (int k = 1; k <= 8; k++) do_pop(3, k);

        // Asynchronous reset mid-fill with an intercore request pending
        do_cfg(1, 6);
        ic_req_valid = 1'b1;
        ic_req_core  = 3'd0;
        tick();
        ic_req_valid = 1'b0;
        check("pre_rst_pending", ic_req_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_counts", slot_counts, 0);
        check("arst_valids", slot_valids, 0);
        check("arst_busys", slot_busys, 0);
        check("arst_ready", ic_req_ready, 1'b1);
        check("arst_resp", {ic_resp_valid, ic_resp_ok, ic_resp_desc}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("arst_no_resp", ic_resp_valid, 1'b0);
            check("arst_no_fill", cnt_of(1), 0);
            tick();
        end

        check("pop_q_empty", exp_q.size(), 0);
        check("ic_q_empty", ic_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
